// File: rtl/gsim_band_mult_if.sv
// gsim_band_mult_if
//   Bundles the serial vector-in / serial result-out signals of the banded
//   forward operator so the producer and the operator share one port.
//   Signals:
//     in_en     master->slave  x_in valid (one element per cycle, index 1 first)
//     x_in      master->slave  signed Q(X_W-FRAC).FRAC solution element
//     busy      slave->master  operator is loading, computing or emitting
//     out_valid slave->master  b_out/sat carry a result row this cycle
//     b_out     slave->master  rounded, saturated signed integer row value
//     sat       slave->master  b_out was clipped to the B_W-bit range
interface gsim_band_mult_if #(
  parameter int X_W = 32,
  parameter int B_W = 16
);
  logic                  in_en;
  logic signed [X_W-1:0] x_in;
  logic                  busy;
  logic                  out_valid;
  logic signed [B_W-1:0] b_out;
  logic                  sat;

  modport master (
    output in_en, x_in,
    input  busy, out_valid, b_out, sat
  );

  modport slave (
    input  in_en, x_in,
    output busy, out_valid, b_out, sat
  );
endinterface

// File: rtl/gsim_band_mult.sv
// gsim_band_mult
//   Forward operator b = A*x for the fixed 7-diagonal symmetric band matrix
//   (diagonal 20, +-1: -13, +-2: 6, +-3: -1) used by the banded Gauss-Seidel
//   solver. A vector of N Q16.16 words is loaded serially, one row per cycle
//   is then computed into a result buffer, and finally the N rows are
//   streamed out as rounded, saturated B_W-bit integers.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, clears every register
//     bus    gsim_band_mult_if.slave (in_en, x_in, busy, out_valid, b_out, sat)
module gsim_band_mult #(
  parameter int N    = 16,
  parameter int X_W  = 32,
  parameter int FRAC = 16,
  parameter int B_W  = 16
) (
  input logic              clk,
  input logic              reset,
  gsim_band_mult_if.slave  bus
);

  localparam int ACC_W = 40;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  localparam logic signed [ACC_W-1:0] C_DIAG = ACC_W'(20);
  localparam logic signed [ACC_W-1:0] C_OFF1 = ACC_W'(13);
  localparam logic signed [ACC_W-1:0] C_OFF2 = ACC_W'(6);
  localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(longint'(1) << (FRAC - 1));
  localparam logic signed [ACC_W-1:0] B_MAX  = ACC_W'((longint'(1) << (B_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] B_MIN  = ~B_MAX;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] ALL_OUT  = CNT_W'(N);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, state_next;

  logic signed [X_W-1:0] x_mem   [N];
  logic signed [B_W-1:0] res_mem [N];
  logic [N-1:0]          sat_mem;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;

  logic                  out_valid_q;
  logic signed [B_W-1:0] b_out_q;
  logic                  sat_q;

  logic signed [ACC_W-1:0] row_acc;
  logic signed [ACC_W-1:0] row_rnd;
  logic signed [B_W-1:0]   row_b;
  logic                    row_sat;
  int                      row_i;

  assign idx           = cnt[IDX_W-1:0];
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.b_out     = b_out_q;
  assign bus.sat       = sat_q;

  // Element j of x, sign-extended; rows near either end see zeros outside
  // the vector, which truncates the band instead of wrapping it.
  function automatic logic signed [ACC_W-1:0] tap(input int row, input int off);
    int j;
    j = row + off;
    if (j < 0 || j >= N) return '0;
    return ACC_W'(x_mem[j[IDX_W-1:0]]);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A gap in in_en while loading abandons the vector; once the last word is
  // in, in_en is ignored until the results have been streamed out.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_en) state_next = LOAD;
      LOAD: begin
        if (!bus.in_en)            state_next = IDLE;
        else if (cnt == LAST_IDX)  state_next = COMPUTE;
      end
      COMPUTE: if (cnt == LAST_IDX) state_next = OUTPUT;
      OUTPUT:  if (cnt == ALL_OUT)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One band row per cycle. |coefficients| sum to 60, so a 40-bit
  // accumulator cannot overflow for any 32-bit input. The arithmetic shift
  // after adding one half floors, giving round-half-toward-+infinity.
  always_comb begin
    row_i   = int'(cnt);
    row_acc = C_DIAG * tap(row_i, 0)
            - C_OFF1 * (tap(row_i, -1) + tap(row_i, 1))
            + C_OFF2 * (tap(row_i, -2) + tap(row_i, 2))
            - (tap(row_i, -3) + tap(row_i, 3));
    row_rnd = (row_acc + HALF) >>> FRAC;
    row_b   = row_rnd[B_W-1:0];
    row_sat = 1'b0;
    if (row_rnd > B_MAX) begin
      row_b   = B_MAX[B_W-1:0];
      row_sat = 1'b1;
    end else if (row_rnd < B_MIN) begin
      row_b   = B_MIN[B_W-1:0];
      row_sat = 1'b1;
    end
  end

  // cnt is the element index while loading, the row index while computing,
  // and the row being presented while emitting; in OUTPUT it runs to N so
  // the extra edge can drop out_valid. b_out/sat keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
      sat_q       <= 1'b0;
      sat_mem     <= '0;
      for (int i = 0; i < N; i++) begin
        x_mem[i]   <= '0;
        res_mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          out_valid_q <= 1'b0;
          cnt         <= '0;
          if (bus.in_en) begin
            x_mem[0] <= bus.x_in;
            cnt      <= CNT_W'(1);
          end
        end
        LOAD: begin
          if (bus.in_en) begin
            x_mem[idx] <= bus.x_in;
            cnt        <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        COMPUTE: begin
          res_mem[idx] <= row_b;
          sat_mem[idx] <= row_sat;
          cnt          <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
        end
        OUTPUT: begin
          if (cnt == ALL_OUT) begin
            out_valid_q <= 1'b0;
            cnt         <= '0;
          end else begin
            out_valid_q <= 1'b1;
            b_out_q     <= res_mem[idx];
            sat_q       <= sat_mem[idx];
            cnt         <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
